// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Package  : dmem_pkg
// Purpose  : state/port encodings and address rule shared by the data-memory arbiter
// Revision : 1.0
// ============================================================================
package dmem_pkg;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } dmem_req_t;

  // Byte address must fall inside the RAM and be word aligned.
  function automatic logic addr_legal(input logic [31:0] addr, input int unsigned ram_size);
    return (addr < ram_size) && (addr[1:0] == 2'b00);
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Purpose  : round-robin two-port (CPU / DMA) arbiter in front of the single-port data RAM
// Revision : 1.0
// ============================================================================
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int unsigned RAM_SIZE = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  output logic        ack0,
  output logic        ack1,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  logic [1:0]  state_q, state_d;
  logic        last_q, last_d;
  logic        winner_q, winner_d;
  logic        illegal_q, illegal_d;
  logic        ack0_q, ack0_d;
  logic        ack1_q, ack1_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;
  logic        mem_rd_q, mem_rd_d;
  logic        mem_wr_q, mem_wr_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;

  logic        elig0;
  logic        elig1;
  logic        grant_valid;
  logic        grant_port;
  logic        sel_legal;
  dmem_req_t   req_sel;

  // Sole requester wins; on a tie the port that was not served last wins.
  function automatic logic rr_pick(input logic r0, input logic r1, input logic last);
    return (r0 && r1) ? ~last : r1;
  endfunction

  always_comb begin
    elig0 = req0;
    elig1 = req1;
    // The port being acked still holds req for the access that is finishing.
    if (state_q == DONE) begin
      if (winner_q == PORT_DMA) begin
        elig1 = 1'b0;
      end else begin
        elig0 = 1'b0;
      end
    end
    grant_valid = elig0 | elig1;
    grant_port  = rr_pick(elig0, elig1, last_q);

    if (grant_port == PORT_DMA) begin
      req_sel.we    = we1;
      req_sel.addr  = addr1;
      req_sel.wdata = wdata1;
    end else begin
      req_sel.we    = we0;
      req_sel.addr  = addr0;
      req_sel.wdata = wdata0;
    end
    sel_legal = addr_legal(req_sel.addr, RAM_SIZE);
  end

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    winner_d    = winner_q;
    illegal_d   = illegal_q;
    mem_rd_d    = mem_rd_q;
    mem_wr_d    = mem_wr_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    ack0_d      = 1'b0;
    ack1_d      = 1'b0;
    err_d       = 1'b0;
    rdata_d     = '0;

    case (state_q)
      IDLE, DONE: begin
        if (grant_valid) begin
          state_d     = ACCESS;
          last_d      = grant_port;
          winner_d    = grant_port;
          illegal_d   = ~sel_legal;
          mem_addr_d  = req_sel.addr;
          mem_wdata_d = req_sel.wdata;
          mem_rd_d    = sel_legal & ~req_sel.we;
          mem_wr_d    = sel_legal &  req_sel.we;
        end else begin
          state_d = IDLE;
        end
      end

      ACCESS: begin
        // The RAM commits the write / presents read data across this closing edge.
        state_d  = DONE;
        mem_rd_d = 1'b0;
        mem_wr_d = 1'b0;
        ack0_d   = (winner_q == PORT_CPU);
        ack1_d   = (winner_q == PORT_DMA);
        err_d    = illegal_q;
        rdata_d  = mem_rd_q ? mem_rdata : 32'd0;
      end

      default: begin
        state_d  = IDLE;
        mem_rd_d = 1'b0;
        mem_wr_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      last_q      <= PORT_DMA;
      winner_q    <= PORT_CPU;
      illegal_q   <= 1'b0;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      winner_q    <= winner_d;
      illegal_q   <= illegal_d;
      ack0_q      <= ack0_d;
      ack1_q      <= ack1_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
      mem_rd_q    <= mem_rd_d;
      mem_wr_q    <= mem_wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign ack0      = ack0_q;
  assign ack1      = ack1_q;
  assign err_o     = err_q;
  assign rdata_o   = rdata_q;
  assign mem_rd    = mem_rd_q;
  assign mem_wr    = mem_wr_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule
`default_nettype wire
